// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//
// Purpose:
//   8N1 UART receiver with an oversampling baud counter. The block finds a
//   falling start edge, confirms it at mid-bit, and samples eight data bits
//   LSB first at mid-bit. It then checks the stop bit. A good frame updates
//   rx_data and the two nibble outputs for the seven-segment decoders, and
//   pulses rx_valid. A bad stop bit pulses frame_err once. The receiver then
//   waits for the line to return high, so a held break reports one error only.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (8..65535), default 434
//                 (50 MHz / 115200 baud)
//
// Ports:
//   clk        in   system clock, all state changes on rising edge
//   rst        in   asynchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   rx_data    out  [7:0] last correctly framed byte
//   rx_valid   out  one-cycle strobe, new rx_data available
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   busy       out  high whenever the receiver is not idle
//   hex_hi     out  [3:0] registered copy of rx_data[7:4]
//   hex_lo     out  [3:0] registered copy of rx_data[3:0]
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [3:0] hex_hi,
    output logic [3:0] hex_lo
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter guard
    // -------------------------------------------------------------------------
    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_rx_core: CLKS_PER_BIT must be in 8..65535");
    end

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    // Wide enough to hold CLKS_PER_BIT-1 and no wider.
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Terminal counts: the counter runs 0..N-1, so the sample happens on the
    // N-th cycle spent in the state.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] RECOVER = 3'd4;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // Decoded sample points
    logic half_done;
    logic bit_done;
    logic stop_sample;
    logic frame_good;
    logic frame_bad;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer. It resets to the idle line level, so leaving
    // reset cannot look like a start edge.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its pre-edge inputs. This is what makes the two stages a
    // real two-cycle pipeline and not a single wire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Sample-point decode
    // -------------------------------------------------------------------------
    // NOTE: every signal driven from always_comb gets a default on entry. A
    // missing branch then cannot infer a latch.
    always_comb begin
        half_done   = 1'b0;
        bit_done    = 1'b0;
        stop_sample = 1'b0;
        frame_good  = 1'b0;
        frame_bad   = 1'b0;

        half_done   = (baud_cnt == HALF_LAST);
        bit_done    = (baud_cnt == BIT_LAST);
        stop_sample = (state == STOP) && bit_done;
        frame_good  = stop_sample &&  rx_s;
        frame_bad   = stop_sample && !rx_s;
    end

    // -------------------------------------------------------------------------
    // Receive FSM with baud counter and bit index
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end

                // Re-check the line at mid start bit. A short glitch returns
                // to IDLE here without any strobe.
                START: begin
                    if (half_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // The mid-start alignment carries forward. A full bit period
                // later lands on the middle of each data bit.
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // Leave STOP at mid stop bit, not at its end. That gives
                // half a bit of slack for the next start edge when frames
                // arrive back to back.
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? IDLE : RECOVER;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // Wait out a break. Only a return to idle-high re-arms the
                // start detector.
                RECOVER: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Data shift register: one mid-bit sample per data bit, LSB first
    // -------------------------------------------------------------------------
    // NOTE: the shift register is only eight flops, so it is cleared on reset
    // like any other control flop. This keeps reset state deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (state == DATA && bit_done) begin
            shift_reg[bit_idx] <= rx_s;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers. The strobes default low every cycle, so each is a
    // single-cycle pulse. frame_good and frame_bad are mutually exclusive,
    // so rx_valid and frame_err can never be high together.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= 8'h00;
            hex_hi    <= 4'h0;
            hex_lo    <= 4'h0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (frame_good) begin
                rx_data  <= shift_reg;
                hex_hi   <= shift_reg[7:4];
                hex_lo   <= shift_reg[3:0];
                rx_valid <= 1'b1;
            end else if (frame_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//
// Self-checking bench for uart_rx_core with CLKS_PER_BIT = 16.
//
// Frames are driven onto rx with a fractional bit period, so skewed baud rates
// can be produced. For each frame that must be reported, the bench queues the
// byte, the strobe kind and the cycle at which the strobe is due. The due
// cycle is the start edge plus 2 synchronizer cycles, plus 1 detect cycle,
// plus half a bit, plus nine full bits. A compare process runs on every
// falling clock edge and checks the following:
//   - strobes against that queue;
//   - rx_data and the nibble outputs against the last good byte;
//   - the strobe exclusivity rule;
//   - the reset values while rst is high.
// Directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int CLKS = 16;
    localparam int LAT  = 3 + CLKS / 2 + 9 * CLKS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic [3:0] hex_hi;
    logic [3:0] hex_lo;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        bit         good;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_data     = 8'h00;
    int         n_valid        = 0;
    int         n_err          = 0;
    int         last_valid_cyc = 0;
    logic       prev_valid     = 1'b0;

    uart_rx_core #(.CLKS_PER_BIT(CLKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .hex_hi    (hex_hi),
        .hex_lo    (hex_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Compare process
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            model_data = 8'h00;
            prev_valid = 1'b0;
            check("rst_rx_data",   32'(rx_data),   32'h00);
            check("rst_hex_hi",    32'(hex_hi),    32'h0);
            check("rst_hex_lo",    32'(hex_lo),    32'h0);
            check("rst_rx_valid",  32'(rx_valid),  32'h0);
            check("rst_frame_err", 32'(frame_err), 32'h0);
            check("rst_busy",      32'(busy),      32'h0);
        end else begin
            check("strobe_exclusive", 32'(rx_valid & frame_err), 32'h0);
            if (prev_valid)
                check("busy_after_valid", 32'(busy), 32'h0);
            if (rx_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'({rx_valid, frame_err}), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_cycle",     32'(cyc),       32'(e.due));
                    check("strobe_valid",     32'(rx_valid),  32'(e.good));
                    check("strobe_frame_err", 32'(frame_err), 32'(!e.good));
                    if (e.good)
                        model_data = e.data;
                end
                if (rx_valid) begin
                    n_valid        = n_valid + 1;
                    last_valid_cyc = cyc;
                end else begin
                    n_err = n_err + 1;
                end
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check("missed_strobe", 32'(cyc), 32'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
            check("rx_data", 32'(rx_data), 32'(model_data));
            check("hex_hi",  32'(hex_hi),  32'(model_data[7:4]));
            check("hex_lo",  32'(hex_lo),  32'(model_data[3:0]));
            prev_valid = rx_valid;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers. All tasks start and end just after a rising edge.
    // -------------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        step(n);
    endtask

    // Drive start bit, eight data bits LSB first, then the stop bit.
    // period_x100 is the bit period in hundredths of a clock cycle.
    // Driving stops after max_cycles, and rx keeps its last value.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int period_x100, input int max_cycles,
                              input bit expect_it);
        logic [9:0] bits;
        int         total;
        bits  = {stop_bit, data, 1'b0};
        total = (10 * period_x100 + 99) / 100;
        if (expect_it)
            exp_q.push_back('{data: data, good: stop_bit, due: cyc + LAT});
        for (int c = 0; c < total; c++) begin
            if (c >= max_cycles) break;
            rx = bits[(c * 100) / period_x100];
            step(1);
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int start_cyc;
        int busy_cnt;
        int guard;

        rx  = 1'b1;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        idle(10);
        check("idle_busy", 32'(busy), 32'h0);

        // Single good frame 0xA5
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 1600, 1000, 1'b1);
        idle(4);
        check("a5_latency", 32'(last_valid_cyc - start_cyc), 32'd155);
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        check("a5_hex_hi",  32'(hex_hi),  32'hA);
        check("a5_hex_lo",  32'(hex_lo),  32'h5);
        check("a5_count",   32'(n_valid), 32'd1);

        // Back-to-back frames with zero idle time
        send_frame(8'h00, 1'b1, 1600, 1000, 1'b1);
        send_frame(8'hFF, 1'b1, 1600, 1000, 1'b1);
        send_frame(8'h3C, 1'b1, 1600, 1000, 1'b1);
        idle(5);
        check("b2b_count",   32'(n_valid), 32'd4);
        check("b2b_rx_data", 32'(rx_data), 32'h3C);
        check("b2b_no_err",  32'(n_err),   32'd0);

        // Bad stop bit, then the line held low as a break
        send_frame(8'h5A, 1'b0, 1600, 1000, 1'b1);
        step(40);
        check("break_busy",    32'(busy),    32'h1);
        check("break_one_err", 32'(n_err),   32'd1);
        check("break_keep",    32'(rx_data), 32'h3C);
        check("break_novalid", 32'(n_valid), 32'd4);
        idle(4);
        check("recover_idle",  32'(busy),    32'h0);

        // Four-cycle glitch while idle: a false start
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (busy) busy_cnt++;
        end
        rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (busy) busy_cnt++;
        end
        check("glitch_busy_bounded", 32'(busy_cnt >= 1 && busy_cnt <= 9), 32'h1);
        check("glitch_busy_low",     32'(busy),    32'h0);
        check("glitch_no_strobe",    32'(n_valid + n_err), 32'd5);

        // Reset during data bit 4 of 0x81, then a clean 0x81
        send_frame(8'h81, 1'b1, 1600, 72, 1'b0);
        rst = 1'b1;
        rx  = 1'b1;
        step(3);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_busy",    32'(busy),    32'h0);
        rst = 1'b0;
        idle(20);
        check("postrst_idle", 32'(busy), 32'h0);
        send_frame(8'h81, 1'b1, 1600, 1000, 1'b1);
        idle(4);
        check("r81_rx_data", 32'(rx_data), 32'h81);
        check("r81_hex_hi",  32'(hex_hi),  32'h8);
        check("r81_hex_lo",  32'(hex_lo),  32'h1);

        // Bit period skewed +4% and -4%
        send_frame(8'hC3, 1'b1, 1664, 1000, 1'b1);
        idle(2);
        check("slow_rx_data", 32'(rx_data), 32'hC3);
        send_frame(8'hC3, 1'b1, 1536, 1000, 1'b1);
        idle(10);
        check("fast_rx_data", 32'(rx_data), 32'hC3);

        guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            step(1);
            guard++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("total_valid",   32'(n_valid),      32'd7);
        check("total_err",     32'(n_err),        32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
